// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer: walks a KxK window over every valid output pixel, driving one PE and
// returning each finished window sum over a valid/ready handshake.
module pe_conv_sequencer #(
  parameter int KSIZE   = 3,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int ADDR_W  = 10,
  parameter int WADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  fmap_addr,
  input  logic [15:0]        fmap_data,
  output logic [WADDR_W-1:0] wt_addr,
  input  logic [15:0]        wt_data,
  output logic [15:0]        pe_in1,
  output logic [15:0]        pe_in2,
  output logic [30:0]        pe_initsum,
  input  logic [30:0]        pe_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [30:0]        out_data,
  output logic [7:0]         out_row,
  output logic [7:0]         out_col
);
  typedef enum logic [2:0] {IDLE, FETCH, MAC, OUT, DONE} state_t;
  localparam logic [WADDR_W-1:0] KM1  = WADDR_W'(KSIZE - 1);
  localparam logic [7:0]         OWM1 = 8'(IMG_W - KSIZE);
  localparam logic [7:0]         OHM1 = 8'(IMG_H - KSIZE);
  state_t               state_q, state_d;
  logic [7:0]           row_q, row_d, col_q, col_d;
  logic [WADDR_W-1:0]   ky_q, ky_d, kx_q, kx_d;
  logic [30:0]          acc_q, acc_d;
  logic [ADDR_W-1:0]    fmap_addr_q, fmap_addr_d;
  logic [WADDR_W-1:0]   wt_addr_q, wt_addr_d;
  logic                 last_tap, last_win, hs;
  assign last_tap = (kx_q == KM1) && (ky_q == KM1);
  assign last_win = (col_q == OWM1) && (row_q == OHM1);
  assign hs       = (state_q == OUT) && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      acc_q       <= '0;
      fmap_addr_q <= '0;
      wt_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      acc_q       <= acc_d;
      fmap_addr_q <= fmap_addr_d;
      wt_addr_q   <= wt_addr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = MAC;
      MAC:     state_d = last_tap ? OUT : FETCH;
      OUT:     state_d = !out_ready ? OUT : last_win ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Counters advance on the MAC and handshake edges; addresses are registered from the next values
  // so the FETCH cycle already presents the upcoming tap.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ky_d  = ky_q;
    kx_d  = kx_q;
    acc_d = acc_q;
    if (state_q == IDLE && start) begin
      row_d = '0;
      col_d = '0;
      ky_d  = '0;
      kx_d  = '0;
      acc_d = '0;
    end else if (state_q == MAC) begin
      acc_d = pe_result;
      kx_d  = (kx_q < KM1) ? kx_q + 1'b1 : (ky_q < KM1) ? '0 : kx_q;
      ky_d  = (kx_q < KM1) ? ky_q : (ky_q < KM1) ? ky_q + 1'b1 : ky_q;
    end else if (hs) begin
      acc_d = '0;
      ky_d  = '0;
      kx_d  = '0;
      col_d = (col_q < OWM1) ? col_q + 1'b1 : (row_q < OHM1) ? '0 : col_q;
      row_d = (col_q < OWM1) ? row_q : (row_q < OHM1) ? row_q + 1'b1 : row_q;
    end
    fmap_addr_d = ADDR_W'((int'(row_d) + int'(ky_d)) * IMG_W + int'(col_d) + int'(kx_d));
    wt_addr_d   = WADDR_W'(int'(ky_d) * KSIZE + int'(kx_d));
  end
  always_comb begin
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    out_valid  = state_q == OUT;
    out_data   = acc_q;
    out_row    = row_q;
    out_col    = col_q;
    fmap_addr  = fmap_addr_q;
    wt_addr    = wt_addr_q;
    pe_in1     = fmap_data;
    pe_in2     = wt_data;
    pe_initsum = acc_q;
  end
endmodule

// File: doc/pe_conv_sequencer.md
Name: pe_conv_sequencer

Overview:
- Sequences one PE multiply-accumulate datapath across a K×K convolution window for every valid output pixel of a single-channel feature map.
- Generates feature-map and weight read addresses and drives the PE operands.
- Holds the running partial sum in a register fed back to the PE `initsum` input.
- Emits each finished 31-bit sum over a valid/ready handshake.
- Sits between the feature-map/weight buffers and the next layer's input buffer.

Parameters:
- KSIZE, 3, kernel edge length K (taps = K*K).
- IMG_W, 28, input feature-map width in pixels.
- IMG_H, 28, input feature-map height in pixels.
- ADDR_W, 10, width of fmap_addr; must hold IMG_W*IMG_H-1.
- WADDR_W, 4, width of wt_addr; must hold K*K-1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to process the whole map; ignored unless idle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last output handshake.
- fmap_addr  out  ADDR_W  feature-map read address; synchronous memory, 1-cycle latency.
- fmap_data  in  16  feature-map word, valid the cycle after fmap_addr.
- wt_addr  out  WADDR_W  weight read address; 1-cycle latency.
- wt_data  in  16  weight word, valid the cycle after wt_addr.
- pe_in1  out  16  PE operand 1 (= fmap_data).
- pe_in2  out  16  PE operand 2 (= wt_data).
- pe_initsum  out  31  PE accumulate input (= acc register).
- pe_result  in  31  PE output: saturating 31-bit two's-complement sum.
- out_valid  out  1  finished sum available.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  31  finished window sum.
- out_row  out  8  output row index of out_data.
- out_col  out  8  output column index of out_data.

Behaviour:
- Output grid: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1. Valid convolution with no padding and stride 1. Raster order: row-major, col fastest.
- Registers: state, row, col, ky, kx, acc[30:0].
- Reset: state=IDLE; row, col, ky, kx = 0; acc=0; busy=0; done=0; out_valid=0; fmap_addr=0; wt_addr=0. Reset mid-operation aborts immediately with the same values. No output is issued for a partially accumulated window.
- Addresses are registered outputs:
  - fmap_addr = (row+ky)*IMG_W + (col+kx)
  - wt_addr = ky*K + kx
- pe_in1/pe_in2/pe_initsum are combinational from fmap_data, wt_data and acc. They are don't-care outside MAC.
- IDLE:
  - start=1 → FETCH. Clear row, col, ky, kx and acc; set busy.
- FETCH (1 cycle): addresses for tap (ky,kx) are presented. → MAC.
- MAC (1 cycle): memory data is valid and acc <= pe_result at the end of the cycle.
  - If kx<K-1: kx++, → FETCH.
  - Else if ky<K-1: kx=0, ky++, → FETCH.
  - Else: → OUT.
- Per-window latency is 2*K*K cycles. acc already includes the last tap on entry to OUT.
- OUT:
  - Drive out_valid=1, out_data=acc, out_row=row, out_col=col. These are held stable while out_ready=0.
  - On out_valid&&out_ready:
    - Clear acc, ky and kx.
    - If col<OUT_W-1: col++, → FETCH.
    - Else if row<OUT_H-1: col=0, row++, → FETCH.
    - Else → DONE.
  - out_valid drops the cycle after the handshake.
- DONE (1 cycle): done=1, busy=0 on the next cycle, → IDLE.
- start while busy is ignored: no restart, no effect on any counter.
- Arithmetic: the sequencer performs no arithmetic on data. Overflow and saturation are owned by the PE. acc takes pe_result verbatim, including the saturated values 31'h3FFF_FFFF and 31'h4000_0000.
- Total cycles per map: OUT_W*OUT_H*(2*K*K + 1 + stall cycles) + 1 (DONE).

Test Plan:
- IMG 4×4, K=3, all fmap=16'h0001, all weights=16'h0001, out_ready=1; start sampled at edge t → first out_valid at t+19 with out_data=9.
  - Four outputs at (0,0), (0,1), (1,0), (1,1), all equal to 9.
  - done pulses once, 1 cycle after the 4th handshake.
- Same setup with weights=16'hFFFF (-1) → every out_data=31'h7FFF_FFF7 (-9).
- fmap[i]=i (0..15), weights=1, IMG 4×4 → outputs 45, 54, 81, 90 in raster order.
  - Capture the address trace for window (0,0): fmap_addr sequence 0,1,2,4,5,6,8,9,10; wt_addr 0..8.
- Hold out_ready=0 for 5 cycles at the first OUT → out_valid, out_data, out_row and out_col stay constant; no new fmap_addr issued; the second window starts the cycle after out_ready rises.
- Pulse start again at cycle t+7 while busy → no effect; the output sequence and done timing are identical to the first scenario.
- Assert rst for 1 cycle during the third window's MAC → next cycle state=IDLE, busy=0, out_valid=0, acc=0.
  - A subsequent start yields all four outputs from scratch (first value 9).
